axis_cmult: RTL and testbench
=============================

Name: axis_cmult

Overview:
- Parametrised, fully pipelined complex multiplier with two joined AXI-Stream inputs (A and B) and one AXI-Stream output.
- Computes A*B or A*conj(B) per beat, with a programmable right shift, optional rounding and saturation to a configurable output width.
- Sits in the DSP datapath after the mixer/NCO stages, e.g. for frequency translation and matched-filter correlation.
- Each beat carries its own B operand on a second stream, unlike the older static-coefficient multiplier.

Parameters:
- IN_WIDTH, 16, width of each real/imag input component (signed).
- OUT_WIDTH, 16, width of each real/imag output component (signed).
- SHIFT, 15, arithmetic right shift applied to the full-precision sum; legal range 0..2*IN_WIDTH.
- ROUND, 1, 1 = round half up before the shift (adds 1<<(SHIFT-1) when SHIFT>0); 0 = truncate.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous active-high reset
- s_axis_a_tdata  in  2*IN_WIDTH  {imag, real}, real in the LSBs
- s_axis_a_tvalid  in  1  A valid
- s_axis_a_tready  out  1  A ready
- s_axis_a_tlast  in  1  frame end; forwarded to the output
- s_axis_b_tdata  in  2*IN_WIDTH  {imag, real}
- s_axis_b_tvalid  in  1  B valid
- s_axis_b_tready  out  1  B ready
- conj_b  in  1  1 = use conj(B); sampled with each accepted beat
- m_axis_tdata  out  2*OUT_WIDTH  {imag, real}
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  forwarded tlast
- ovf_sticky  out  1  set when any output component saturated
- ovf_clr  in  1  synchronous clear of ovf_sticky

Behaviour:
- Reset (async assert, synchronous release):
  - All stage valids, m_axis_tvalid, m_axis_tlast and ovf_sticky go to 0.
  - Data registers go to 0.
  - Both tready outputs are 0 while areset is high.
- Join handshake:
  - accept = !v1 || adv1.
  - s_axis_a_tready = s_axis_b_tvalid && accept.
  - s_axis_b_tready = s_axis_a_tvalid && accept.
  - A beat is consumed only when both tvalid are high and accept is high, so neither stream is ever consumed alone.
  - tlast is taken from A; B carries no tlast.
- Pipeline: three register stages, each with its own valid bit. Stage i advances when !v(i+1) || adv(i+1), and adv3 = m_axis_tready.
  - S1: four signed products ar*br, ai*bi, ar*bi, ai*br, each 2*IN_WIDTH bits, plus the conj flag and tlast.
  - S2: full-precision sums, 2*IN_WIDTH+1 bits.
    - conj=0: re = ar*br - ai*bi, im = ar*bi + ai*br.
    - conj=1: re = ar*br + ai*bi, im = ai*br - ar*bi.
  - S3 (output register): optional round, arithmetic shift right by SHIFT, saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Timing and flow:
  - Latency is 3 cycles from input handshake to m_axis_tvalid, with no stall.
  - Throughput is 1 beat/cycle.
  - Bubbles collapse: a stalled output lets upstream stages fill before input ready drops.
  - Up to 3 beats are held under backpressure. No beat is lost or duplicated, and order is preserved.
- AXI-S compliance:
  - m_axis_tdata, tvalid and tlast are stable while tvalid=1 and tready=0.
  - Output valid never depends combinationally on the inputs.
- ovf_sticky:
  - Set on the cycle a saturated value is loaded into S3.
  - ovf_clr clears it. If ovf_clr and a new saturation occur in the same cycle, set wins.
- Reset mid-frame: in-flight beats are discarded and no partial output is emitted after release.

Decomposition:
- A shared include/package (axis_cmult_pkg) holds:
  - PROD_W = 2*IN_WIDTH and SUM_W = 2*IN_WIDTH+1 localparam functions.
  - The round-constant function.
  - The saturation min/max constants.
- One sub-module, cmult_round_sat (combinational):
  - Input: SUM_W value. Output: OUT_WIDTH value plus an overflow flag.
  - Instantiated twice, for re and im.
- Multipliers are inferred in S1 and marked for DSP mapping.

Test Plan:
- Basic, defaults: A=(re 0x4000, im 0), B=(0x4000, 0x4000), conj=0 -> m_axis_tdata=32'h2000_2000 exactly 3 cycles after the handshake; ovf_sticky=0.
- Conjugate: same operands with conj=1 -> 32'hE000_2000; toggle conj every beat over 6 beats and check each output uses its own beat's flag.
- Saturation: A=(-32768, 0), B=(-32768, 0) -> re saturates to 0x7FFF, tdata 32'h0000_7FFF, ovf_sticky=1.
  - Assert ovf_clr -> ovf_sticky=0 next cycle.
  - Simultaneous clr and saturation -> ovf_sticky stays 1.
- Rounding: A=(1, 0), B=(16384, 0) -> re=1 with ROUND=1, re=0 with ROUND=0 (second build).
  - Negative half: A=(-1, 0), B=(16384, 0) -> re=0 with ROUND=1.
- Join/backpressure:
  - A valid while B is idle for 5 cycles -> no transfer, s_axis_a_tready=0.
  - Then stream 8 beats with tlast on the 8th, holding m_axis_tready low for cycles 4-13 -> exactly 8 outputs, in order, tlast only on the 8th, data stable while stalled.
- Async reset mid-stream: assert areset between clock edges with 3 beats in flight -> m_axis_tvalid=0 immediately, no stale output after release, the next beat has latency 3.

Source files
------------

// File: rtl/axis_cmult_pkg.sv
// rtl/axis_cmult_pkg.sv - shared widths, rounding and saturation helpers for axis_cmult
package axis_cmult_pkg;

  function automatic int prod_w(input int in_width);
    return 2 * in_width;
  endfunction

  // One guard bit so that the sum of two full-scale products cannot wrap.
  function automatic int sum_w(input int in_width);
    return 2 * in_width + 1;
  endfunction

  function automatic longint round_const(input int shift, input int round);
    return (round != 0 && shift > 0) ? (64'sd1 <<< (shift - 1)) : 64'sd0;
  endfunction

  function automatic longint sat_max(input int out_width);
    return (64'sd1 <<< (out_width - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int out_width);
    return -(64'sd1 <<< (out_width - 1));
  endfunction

endpackage

// File: rtl/cmult_round_sat.sv
// rtl/cmult_round_sat.sv - round, arithmetic right shift and saturate one component
module cmult_round_sat
  import axis_cmult_pkg::*;
#(
  parameter int SUM_W     = 33,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 15,
  parameter int ROUND     = 1
) (
  input  logic signed [SUM_W-1:0]     sum,
  output logic        [OUT_WIDTH-1:0] dout,
  output logic                        ovf
);

  // Wide enough that the rounding add and the range compare never wrap.
  localparam int WIDE = SUM_W + OUT_WIDTH + 1;
  localparam logic signed [WIDE-1:0] RC   = WIDE'(round_const(SHIFT, ROUND));
  localparam logic signed [WIDE-1:0] MAXV = WIDE'(sat_max(OUT_WIDTH));
  localparam logic signed [WIDE-1:0] MINV = WIDE'(sat_min(OUT_WIDTH));

  logic signed [WIDE-1:0] ext;
  logic signed [WIDE-1:0] shifted;

  always_comb begin
    ext     = WIDE'(sum) + RC;
    shifted = ext >>> SHIFT;
    dout    = shifted[OUT_WIDTH-1:0];
    ovf     = 1'b0;
    if (shifted > MAXV) begin
      dout = MAXV[OUT_WIDTH-1:0];
      ovf  = 1'b1;
    end else if (shifted < MINV) begin
      dout = MINV[OUT_WIDTH-1:0];
      ovf  = 1'b1;
    end
  end

endmodule

// File: rtl/axis_cmult.sv
// rtl/axis_cmult.sv - three-stage AXI-Stream complex multiplier, A*B or A*conj(B) per beat
module axis_cmult
  import axis_cmult_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 15,
  parameter int ROUND     = 1
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [2*IN_WIDTH-1:0]    s_axis_a_tdata,
  input  logic                     s_axis_a_tvalid,
  output logic                     s_axis_a_tready,
  input  logic                     s_axis_a_tlast,
  input  logic [2*IN_WIDTH-1:0]    s_axis_b_tdata,
  input  logic                     s_axis_b_tvalid,
  output logic                     s_axis_b_tready,
  input  logic                     conj_b,
  output logic [2*OUT_WIDTH-1:0]   m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     ovf_sticky,
  input  logic                     ovf_clr
);

  localparam int PROD_W = prod_w(IN_WIDTH);
  localparam int SUM_W  = sum_w(IN_WIDTH);

  logic v1, v2, v3;
  logic adv1, adv2, accept, take;

  // Each stage refills whenever the one below is empty or draining.
  assign adv2   = !v3 || m_axis_tready;
  assign adv1   = !v2 || adv2;
  assign accept = !v1 || adv1;

  assign s_axis_a_tready = !areset && s_axis_b_tvalid && accept;
  assign s_axis_b_tready = !areset && s_axis_a_tvalid && accept;
  assign take            = s_axis_a_tvalid && s_axis_b_tvalid && accept;

  logic signed [IN_WIDTH-1:0] ar, ai, br, bi;
  assign ar = s_axis_a_tdata[IN_WIDTH-1:0];
  assign ai = s_axis_a_tdata[2*IN_WIDTH-1:IN_WIDTH];
  assign br = s_axis_b_tdata[IN_WIDTH-1:0];
  assign bi = s_axis_b_tdata[2*IN_WIDTH-1:IN_WIDTH];

  (* use_dsp = "yes" *) logic signed [PROD_W-1:0] p_rr;
  (* use_dsp = "yes" *) logic signed [PROD_W-1:0] p_ii;
  (* use_dsp = "yes" *) logic signed [PROD_W-1:0] p_ri;
  (* use_dsp = "yes" *) logic signed [PROD_W-1:0] p_ir;
  logic c1, l1;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      v1   <= 1'b0;
      c1   <= 1'b0;
      l1   <= 1'b0;
      p_rr <= '0;
      p_ii <= '0;
      p_ri <= '0;
      p_ir <= '0;
    end else if (accept) begin
      v1   <= take;
      c1   <= conj_b;
      l1   <= s_axis_a_tlast;
      p_rr <= PROD_W'(ar) * PROD_W'(br);
      p_ii <= PROD_W'(ai) * PROD_W'(bi);
      p_ri <= PROD_W'(ar) * PROD_W'(bi);
      p_ir <= PROD_W'(ai) * PROD_W'(br);
    end
  end

  logic signed [SUM_W-1:0] re2, im2;
  logic l2;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      v2  <= 1'b0;
      l2  <= 1'b0;
      re2 <= '0;
      im2 <= '0;
    end else if (adv1) begin
      v2 <= v1;
      l2 <= l1;
      if (c1) begin
        re2 <= SUM_W'(p_rr) + SUM_W'(p_ii);
        im2 <= SUM_W'(p_ir) - SUM_W'(p_ri);
      end else begin
        re2 <= SUM_W'(p_rr) - SUM_W'(p_ii);
        im2 <= SUM_W'(p_ri) + SUM_W'(p_ir);
      end
    end
  end

  logic [OUT_WIDTH-1:0] re_q, im_q;
  logic ovf_re, ovf_im;

  cmult_round_sat #(
    .SUM_W(SUM_W), .OUT_WIDTH(OUT_WIDTH), .SHIFT(SHIFT), .ROUND(ROUND)
  ) u_rs_re (
    .sum(re2), .dout(re_q), .ovf(ovf_re)
  );

  cmult_round_sat #(
    .SUM_W(SUM_W), .OUT_WIDTH(OUT_WIDTH), .SHIFT(SHIFT), .ROUND(ROUND)
  ) u_rs_im (
    .sum(im2), .dout(im_q), .ovf(ovf_im)
  );

  logic [2*OUT_WIDTH-1:0] d3;
  logic l3, ovf_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      v3 <= 1'b0;
      l3 <= 1'b0;
      d3 <= '0;
    end else if (adv2) begin
      v3 <= v2;
      l3 <= l2;
      d3 <= {im_q, re_q};
    end
  end

  // A fresh saturation outranks a clear landing on the same edge.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ovf_q <= 1'b0;
    end else if (adv2 && v2 && (ovf_re || ovf_im)) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign m_axis_tdata  = d3;
  assign m_axis_tvalid = v3;
  assign m_axis_tlast  = l3;
  assign ovf_sticky    = ovf_q;

endmodule

// File: tb/tb_axis_cmult.sv
// tb/tb_axis_cmult.sv - self-checking bench for axis_cmult (rounding and truncating builds)
module tb_axis_cmult;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] s_axis_a_tdata = '0, s_axis_b_tdata = '0;
  logic        s_axis_a_tvalid = 1'b0, s_axis_b_tvalid = 1'b0, s_axis_a_tlast = 1'b0;
  logic        conj_b = 1'b0, m_axis_tready = 1'b1, ovf_clr = 1'b0;
  logic        s_axis_a_tready, s_axis_b_tready, m_axis_tvalid, m_axis_tlast, ovf_sticky;
  logic [31:0] m_axis_tdata;
  logic        t_a_tready, t_b_tready, t_tvalid, t_tlast, t_ovf;
  logic [31:0] t_tdata;

  axis_cmult dut (
    .aclk(aclk), .areset(areset),
    .s_axis_a_tdata(s_axis_a_tdata), .s_axis_a_tvalid(s_axis_a_tvalid),
    .s_axis_a_tready(s_axis_a_tready), .s_axis_a_tlast(s_axis_a_tlast),
    .s_axis_b_tdata(s_axis_b_tdata), .s_axis_b_tvalid(s_axis_b_tvalid),
    .s_axis_b_tready(s_axis_b_tready), .conj_b(conj_b),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  axis_cmult #(.ROUND(0)) dut_trunc (
    .aclk(aclk), .areset(areset),
    .s_axis_a_tdata(s_axis_a_tdata), .s_axis_a_tvalid(s_axis_a_tvalid),
    .s_axis_a_tready(t_a_tready), .s_axis_a_tlast(s_axis_a_tlast),
    .s_axis_b_tdata(s_axis_b_tdata), .s_axis_b_tvalid(s_axis_b_tvalid),
    .s_axis_b_tready(t_b_tready), .conj_b(conj_b),
    .m_axis_tdata(t_tdata), .m_axis_tvalid(t_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(t_tlast),
    .ovf_sticky(t_ovf), .ovf_clr(ovf_clr)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int out_count = 0;
  bit lat_chk = 1'b1;

  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] r;
    logic [31:0] t;
    logic        last;
    int          hs;
    bit          lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cj;
    logic [31:0] er;
    logic [31:0] et;
    logic        eovf;
  } vec_t;
  vec_t tv[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [15:0] sat16(input longint v, input bit rnd);
    longint x;
    x = v;
    if (rnd) x = x + 64'sd16384;
    x = x >>> 15;
    if (x > 64'sd32767) return 16'h7FFF;
    if (x < -64'sd32768) return 16'h8000;
    return x[15:0];
  endfunction

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cj, input bit rnd);
    longint ar, ai, br, bi, re, im;
    ar = longint'($signed(a[15:0]));
    ai = longint'($signed(a[31:16]));
    br = longint'($signed(b[15:0]));
    bi = longint'($signed(b[31:16]));
    re = cj ? (ar * br + ai * bi) : (ar * br - ai * bi);
    im = cj ? (ai * br - ar * bi) : (ar * bi + ai * br);
    return {sat16(im, rnd), sat16(re, rnd)};
  endfunction

  // Output side: pops the scoreboard on each accepted beat, and holds the
  // last stalled beat to confirm it did not move before it was taken.
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  exp_t        mon_e;

  always @(negedge aclk) begin
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_tvalid", m_axis_tvalid, 1);
        check("stall_tdata", m_axis_tdata, prev_data);
        check("stall_tlast", m_axis_tlast, prev_last);
      end
      if (m_axis_tvalid) begin
        if (sb.size() == 0) begin
          fail("unexpected_output");
          prev_stall = 1'b0;
        end else if (m_axis_tready) begin
          mon_e = sb.pop_front();
          out_count++;
          check("tdata", m_axis_tdata, mon_e.r);
          check("tlast", m_axis_tlast, mon_e.last);
          check("trunc_tvalid", t_tvalid, 1);
          check("trunc_tdata", t_tdata, mon_e.t);
          if (mon_e.lat) check("latency", cyc - mon_e.hs + 1, 3);
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_data  = m_axis_tdata;
          prev_last  = m_axis_tlast;
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cj,
                      input logic lst, input logic [31:0] er, input logic [31:0] et);
    int n;
    bit ok;
    s_axis_a_tdata  = a;
    s_axis_b_tdata  = b;
    conj_b          = cj;
    s_axis_a_tlast  = lst;
    s_axis_a_tvalid = 1'b1;
    s_axis_b_tvalid = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge aclk);
      if (s_axis_a_tready && s_axis_b_tready) ok = 1'b1;
      n++;
    end
    if (ok) sb.push_back('{r: er, t: et, last: lst, hs: cyc + 1, lat: lat_chk});
    else fail("send_timeout");
    @(posedge aclk);
    #1;
    s_axis_a_tvalid = 1'b0;
    s_axis_b_tvalid = 1'b0;
    s_axis_a_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge aclk);
      n++;
    end
    if (sb.size() != 0) begin
      fail("drain_timeout");
      sb.delete();
    end
    @(posedge aclk);
    #1;
  endtask

  logic [31:0] ra, rb;
  int cnt0;

  initial begin
    tv[0] = '{a: 32'h0000_4000, b: 32'h4000_4000, cj: 1'b0, er: 32'h2000_2000, et: 32'h2000_2000, eovf: 1'b0};
    tv[1] = '{a: 32'h0000_4000, b: 32'h4000_4000, cj: 1'b1, er: 32'hE000_2000, et: 32'hE000_2000, eovf: 1'b0};
    tv[2] = '{a: 32'h0000_0001, b: 32'h0000_4000, cj: 1'b0, er: 32'h0000_0001, et: 32'h0000_0000, eovf: 1'b0};
    tv[3] = '{a: 32'h0000_FFFF, b: 32'h0000_4000, cj: 1'b0, er: 32'h0000_0000, et: 32'h0000_FFFF, eovf: 1'b0};
    tv[4] = '{a: 32'h0000_8000, b: 32'h0000_8000, cj: 1'b0, er: 32'h0000_7FFF, et: 32'h0000_7FFF, eovf: 1'b1};
    tv[5] = '{a: 32'h8000_8000, b: 32'h8000_7FFF, cj: 1'b0, er: 32'h0001_8000, et: 32'h0001_8000, eovf: 1'b1};

    // Reset state, with both inputs offering data.
    s_axis_a_tvalid = 1'b1;
    s_axis_b_tvalid = 1'b1;
    #12;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_ovf", ovf_sticky, 0);
    check("rst_a_tready", s_axis_a_tready, 0);
    check("rst_b_tready", s_axis_b_tready, 0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    s_axis_a_tvalid = 1'b0;
    s_axis_b_tvalid = 1'b0;
    @(posedge aclk);
    #1;

    foreach (tv[i]) begin
      send(tv[i].a, tv[i].b, tv[i].cj, 1'b0, tv[i].er, tv[i].et);
      drain();
      check("ovf_sticky", ovf_sticky, tv[i].eovf);
      check("trunc_ovf", t_ovf, tv[i].eovf);
    end

    ovf_clr = 1'b1;
    @(posedge aclk);
    #1;
    ovf_clr = 1'b0;
    check("ovf_cleared", ovf_sticky, 0);

    // Clear lands on the same edge the saturated beat enters the output register.
    send(tv[4].a, tv[4].b, 1'b0, 1'b0, tv[4].er, tv[4].et);
    @(posedge aclk);
    #1;
    check("ovf_before_sat", ovf_sticky, 0);
    ovf_clr = 1'b1;
    @(posedge aclk);
    #1;
    ovf_clr = 1'b0;
    check("ovf_set_wins", ovf_sticky, 1);
    drain();
    ovf_clr = 1'b1;
    @(posedge aclk);
    #1;
    ovf_clr = 1'b0;

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      send(ra, rb, i[0], 1'b0, model(ra, rb, i[0], 1'b1), model(ra, rb, i[0], 1'b0));
    end
    drain();

    // A offered alone must never be consumed.
    s_axis_a_tdata  = 32'h1234_5678;
    s_axis_a_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("join_a_tready", s_axis_a_tready, 0);
    end
    @(posedge aclk);
    #1;
    s_axis_a_tvalid = 1'b0;
    check("join_no_output", m_axis_tvalid, 0);

    lat_chk = 1'b0;
    cnt0 = out_count;
    fork
      begin
        logic [31:0] pa, pb;
        for (int i = 0; i < 8; i++) begin
          pa = $urandom;
          pb = $urandom;
          send(pa, pb, 1'b0, (i == 7), model(pa, pb, 1'b0, 1'b1), model(pa, pb, 1'b0, 1'b0));
        end
      end
      begin
        for (int k = 1; k <= 16; k++) begin
          m_axis_tready = !(k >= 4 && k <= 13);
          @(posedge aclk);
          #1;
        end
        m_axis_tready = 1'b1;
      end
    join
    drain();
    check("bp_out_count", out_count - cnt0, 8);

    // Three beats held in the pipeline, then reset between clock edges.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom;
      send(ra, rb, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b1), model(ra, rb, 1'b0, 1'b0));
    end
    @(negedge aclk);
    check("inflight_tvalid", m_axis_tvalid, 1);
    #2;
    areset = 1'b1;
    sb.delete();
    #1;
    check("mid_rst_tvalid", m_axis_tvalid, 0);
    check("mid_rst_tdata", m_axis_tdata, 0);
    s_axis_a_tvalid = 1'b1;
    s_axis_b_tvalid = 1'b1;
    @(negedge aclk);
    check("mid_rst_a_tready", s_axis_a_tready, 0);
    check("mid_rst_b_tready", s_axis_b_tready, 0);
    @(posedge aclk);
    #1;
    s_axis_a_tvalid = 1'b0;
    s_axis_b_tvalid = 1'b0;
    m_axis_tready   = 1'b1;
    areset          = 1'b0;
    repeat (6) @(posedge aclk);
    #1;
    check("post_rst_idle", m_axis_tvalid, 0);
    lat_chk = 1'b1;
    send(tv[0].a, tv[0].b, tv[0].cj, 1'b1, tv[0].er, tv[0].et);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    fail("watchdog");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
